// File: rtl/wavegen_cmd_ctrl_if.sv
// Byte stream from the SPI receiver into the waveform command decoder.
interface wavegen_cmd_ctrl_if;
    logic [7:0] command;
    logic       command_signal;

    modport master (output command, output command_signal);
    modport slave  (input  command, input  command_signal);
endinterface

// File: rtl/wavegen_cmd_ctrl.sv
// Decodes 1..3 byte SPI commands into waveform generator configuration registers,
// with an inter-byte timeout that aborts a stalled multi-byte command.
module wavegen_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    wavegen_cmd_ctrl_if.slave   cmd,
    output logic [1:0]          wave_sel,
    output logic [15:0]         freq_word,
    output logic [7:0]          amplitude,
    output logic                enable,
    output logic                cfg_update,
    output logic                cmd_error,
    output logic                busy
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StGetB1, StGetB2} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_freq_q, is_freq_d;
    logic [7:0]      freq_hi_q, freq_hi_d;
    logic [1:0]      wave_sel_q, wave_sel_d;
    logic [15:0]     freq_word_q, freq_word_d;
    logic [7:0]      amplitude_q, amplitude_d;
    logic            enable_q, enable_d;
    logic            cfg_update_q, cfg_update_d;
    logic            cmd_error_q, cmd_error_d;
    logic            timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_freq_d    = is_freq_q;
        freq_hi_d    = freq_hi_q;
        wave_sel_d   = wave_sel_q;
        freq_word_d  = freq_word_q;
        amplitude_d  = amplitude_q;
        enable_d     = enable_q;
        cfg_update_d = 1'b0;
        cmd_error_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cmd.command_signal) begin
                    unique case (cmd.command[7:4])
                        4'h0: ;
                        4'h1: begin
                            wave_sel_d   = cmd.command[1:0];
                            cfg_update_d = 1'b1;
                        end
                        4'h2: begin
                            state_d   = StGetB1;
                            is_freq_d = 1'b1;
                        end
                        4'h3: begin
                            state_d   = StGetB1;
                            is_freq_d = 1'b0;
                        end
                        4'h4: begin
                            enable_d     = cmd.command[0];
                            cfg_update_d = 1'b1;
                        end
                        default: cmd_error_d = 1'b1;
                    endcase
                end
            end
            StGetB1, StGetB2: begin
                if (cmd.command_signal) begin
                    cnt_d = '0;
                    if (state_q == StGetB2) begin
                        freq_word_d  = {freq_hi_q, cmd.command};
                        cfg_update_d = 1'b1;
                        state_d      = StIdle;
                    end else if (is_freq_q) begin
                        // High byte waits in the shadow so freq_word only ever changes whole.
                        freq_hi_d = cmd.command;
                        state_d   = StGetB2;
                    end else begin
                        amplitude_d  = cmd.command;
                        cfg_update_d = 1'b1;
                        state_d      = StIdle;
                    end
                end else if (timeout) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    freq_hi_d   = '0;
                    cmd_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            is_freq_q    <= 1'b0;
            freq_hi_q    <= '0;
            wave_sel_q   <= 2'd0;
            freq_word_q  <= 16'h0000;
            amplitude_q  <= 8'h80;
            enable_q     <= 1'b0;
            cfg_update_q <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_freq_q    <= is_freq_d;
            freq_hi_q    <= freq_hi_d;
            wave_sel_q   <= wave_sel_d;
            freq_word_q  <= freq_word_d;
            amplitude_q  <= amplitude_d;
            enable_q     <= enable_d;
            cfg_update_q <= cfg_update_d;
            cmd_error_q  <= cmd_error_d;
        end
    end

    assign wave_sel   = wave_sel_q;
    assign freq_word  = freq_word_q;
    assign amplitude  = amplitude_q;
    assign enable     = enable_q;
    assign cfg_update = cfg_update_q;
    assign cmd_error  = cmd_error_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_wavegen_cmd_ctrl.sv
// Directed and random byte streams checked against a queue-based command model.
module tb_wavegen_cmd_ctrl;

    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wave_sel;
    logic [15:0] freq_word;
    logic [7:0]  amplitude;
    logic        enable, cfg_update, cmd_error, busy;

    int n_chk  = 0;
    int n_fail = 0;

    wavegen_cmd_ctrl_if cmd_bus ();

    wavegen_cmd_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (rst),
        .cmd        (cmd_bus),
        .wave_sel   (wave_sel),
        .freq_word  (freq_word),
        .amplitude  (amplitude),
        .enable     (enable),
        .cfg_update (cfg_update),
        .cmd_error  (cmd_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: bytes of the command in progress plus a count of idle clocks since the last byte.
    logic [7:0]  pend[$];
    int          idle;
    logic [1:0]  m_wave;
    logic [15:0] m_freq;
    logic [7:0]  m_amp;
    logic        m_en, m_cfg, m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit stb, input logic [7:0] b);
        m_cfg = 1'b0;
        m_err = 1'b0;
        if (r) begin
            pend.delete();
            idle   = 0;
            m_wave = 2'd0;
            m_freq = 16'h0000;
            m_amp  = 8'h80;
            m_en   = 1'b0;
        end else if (pend.size() == 0) begin
            if (stb) begin
                case (b[7:4])
                    4'h0: ;
                    4'h1: begin m_wave = b[1:0]; m_cfg = 1'b1; end
                    4'h2, 4'h3: begin pend.push_back(b); idle = 0; end
                    4'h4: begin m_en = b[0]; m_cfg = 1'b1; end
                    default: m_err = 1'b1;
                endcase
            end
        end else if (stb) begin
            pend.push_back(b);
            idle = 0;
            if (pend[0][7:4] == 4'h2 && pend.size() == 3) begin
                m_freq = {pend[1], pend[2]};
                m_cfg  = 1'b1;
                pend.delete();
            end else if (pend[0][7:4] == 4'h3 && pend.size() == 2) begin
                m_amp = pend[1];
                m_cfg = 1'b1;
                pend.delete();
            end
        end else begin
            idle++;
            if (idle == T) begin
                pend.delete();
                idle  = 0;
                m_err = 1'b1;
            end
        end
    endtask

    task automatic step(input bit r, input bit stb, input logic [7:0] b);
        rst                    = r;
        cmd_bus.command        = b;
        cmd_bus.command_signal = stb;
        @(posedge clk);
        model(r, stb, b);
        #1;
        chk("wave_sel", 16'(wave_sel), 16'(m_wave));
        chk("freq_word", freq_word, m_freq);
        chk("amplitude", 16'(amplitude), 16'(m_amp));
        chk("enable", 16'(enable), 16'(m_en));
        chk("cfg_update", 16'(cfg_update), 16'(m_cfg));
        chk("cmd_error", 16'(cmd_error), 16'(m_err));
        chk("busy", 16'(busy), 16'(pend.size() != 0));
        chk("pulse_excl", 16'(cfg_update & cmd_error), 16'd0);
    endtask

    initial begin
        cmd_bus.command        = 8'h00;
        cmd_bus.command_signal = 1'b0;
        step(1, 0, 8'h00);
        step(1, 1, 8'h12);
        // Absolute reset values, independent of the model.
        chk("rst_amp", 16'(amplitude), 16'h0080);
        chk("rst_freq", freq_word, 16'h0000);

        step(0, 1, 8'h12);
        chk("wave2", 16'(wave_sel), 16'd2);
        step(0, 1, 8'h41);
        chk("en1", 16'(enable), 16'd1);
        step(0, 0, 8'h00);

        step(0, 1, 8'h20);
        step(0, 1, 8'hAB);
        chk("freq_partial", freq_word, 16'h0000);
        step(0, 1, 8'hCD);
        chk("freq_abcd", freq_word, 16'hABCD);
        step(0, 0, 8'h00);

        step(0, 1, 8'h30);
        step(0, 1, 8'h4F);
        chk("amp_4f", 16'(amplitude), 16'h004F);
        chk("en_kept", 16'(enable), 16'd1);

        step(0, 1, 8'h31);
        step(0, 1, 8'h4F);
        chk("amp_same_cfg", 16'(cfg_update), 16'd1);

        step(0, 1, 8'h20);
        step(0, 1, 8'h12);
        for (int i = 0; i < int'(T); i++) step(0, 0, 8'h00);
        chk("timeout_err", 16'(cmd_error), 16'd1);
        step(0, 1, 8'h13);
        chk("wave3", 16'(wave_sel), 16'd3);

        // Strobe on the last permitted idle clock is still accepted.
        step(0, 1, 8'h30);
        for (int i = 0; i < int'(T) - 1; i++) step(0, 0, 8'h00);
        step(0, 1, 8'h00);
        chk("amp_zero_edge", 16'(amplitude), 16'h0000);

        step(0, 1, 8'h20);
        step(0, 1, 8'h55);
        step(1, 0, 8'h00);
        chk("rst_no_err", 16'(cmd_error), 16'd0);
        step(0, 1, 8'h66);
        chk("illegal_66", 16'(cmd_error), 16'd1);
        step(0, 1, 8'h9A);
        chk("illegal_busy", 16'(busy), 16'd0);
        step(0, 0, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            bit         stb;
            b   = 8'($urandom);
            if ($urandom_range(0, 3) != 0) b[7:4] = 4'($urandom_range(0, 5));
            stb = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 199) == 0) begin
                step(1, stb, b);
            end else if ($urandom_range(0, 59) == 0) begin
                for (int k = 0; k < int'($urandom_range(T - 2, T + 2)); k++) step(0, 0, 8'h00);
            end else begin
                step(0, stb, b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wavegen_cmd_ctrl.md
WAVEGEN_CMD_CTRL -- requirements
Module: wavegen_cmd_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, idle clocks allowed between bytes of one multi-byte command before abort.
REQ-002 clk  input  1  system clock, same clock as the SPI byte receiver.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 command  input  8  received SPI byte; valid only when command_signal is high.
REQ-005 command_signal  input  1  one-clock strobe per received byte; back-to-back strobes are legal.
REQ-006 wave_sel  output  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-007 freq_word  output  16  phase-accumulator tuning word.
REQ-008 amplitude  output  8  output scale factor.
REQ-009 enable  output  1  generator run enable.
REQ-010 cfg_update  output  1  one-clock pulse; an output register changed on the previous edge.
REQ-011 cmd_error  output  1  one-clock pulse on an illegal opcode or a timeout abort.
REQ-012 busy  output  1  high while a multi-byte command is partially received.

Function
REQ-013 Opcode is command[7:4] of the first byte after IDLE; command[3:0] is the immediate field.
REQ-014 Opcode 0x0 NOP: no output change, no pulse.
REQ-015 Opcode 0x1 SET_WAVE (1 byte): wave_sel <= command[1:0].
REQ-016 Opcode 0x2 SET_FREQ (3 bytes): byte 2 = freq_word[15:8], byte 3 = freq_word[7:0].
REQ-017 Opcode 0x3 SET_AMP (2 bytes): byte 2 = amplitude.
REQ-018 Opcode 0x4 SET_EN (1 byte): enable <= command[0].
REQ-019 Opcodes 0x5-0xF: cmd_error pulses; state stays IDLE; no output change.
REQ-020 States: IDLE, GET_B1, GET_B2.
REQ-021 IDLE -> GET_B1 on a strobe carrying SET_FREQ or SET_AMP.
REQ-022 GET_B1 on a strobe: SET_AMP commits and returns to IDLE; SET_FREQ latches the high byte into a shadow register and moves to GET_B2.
REQ-023 GET_B2 on a strobe: SET_FREQ commits and returns to IDLE.
REQ-024 Data bytes are never decoded as opcodes, whatever their value.
REQ-025 Commit is atomic: the target output register updates on the same edge that samples the final byte's strobe.
REQ-026 cfg_update is high for exactly the following cycle, giving 1-clock latency from the final strobe.
REQ-027 cfg_update pulses even when the committed value equals the current value.
REQ-028 Partial freq bytes are never visible on freq_word.
REQ-029 Timeout counter: cleared on entry to GET_B1 and on every accepted byte; increments each GET_B1/GET_B2 clock without a strobe.
REQ-030 When the timeout count reaches TIMEOUT_CYCLES-1 with no strobe: go to IDLE, discard shadows, pulse cmd_error next cycle, leave outputs unchanged.
REQ-031 A strobe in the cycle the count reaches TIMEOUT_CYCLES-1 is accepted; no timeout occurs.
REQ-032 busy = (state != IDLE), registered; it is high in the cycle after the opcode strobe and low in the cycle after the commit or abort.
REQ-033 cfg_update and cmd_error are never high in the same cycle.
REQ-034 freq_word 0x0000 and amplitude 0x00 are legal values and are committed unchanged.

Reset
REQ-035 reset, when sampled high, forces: state IDLE, timeout counter 0, shadows 0, wave_sel 0, freq_word 0x0000, amplitude 0x80, enable 0, cfg_update 0, cmd_error 0, busy 0.
REQ-036 reset overrides a coincident command_signal; a reset mid-command discards the partial command and produces no cmd_error.
REQ-037 After reset deasserts, the first strobe is decoded as an opcode.

Verification
REQ-038 Strobes 0x12 -> wave_sel=2 and cfg_update high one cycle later; then 0x41 -> enable=1 plus one cfg_update pulse.
REQ-039 Back-to-back strobes 0x20, 0xAB, 0xCD -> freq_word stays 0x0000 until the final edge, then 0xABCD; busy high for 2 cycles; one cfg_update pulse.
REQ-040 Strobes 0x30, 0x4F -> amplitude=0x4F, enable unchanged (data byte not decoded as an opcode).
REQ-041 Strobe 0x20, 0x12, then no strobe for TIMEOUT_CYCLES clocks -> one cmd_error pulse, freq_word unchanged, busy low; next strobe 0x13 -> wave_sel=3.
REQ-042 Strobe 0x20, 0x55, reset for 1 cycle, then strobe 0x66 -> outputs at reset values, no cmd_error, 0x66 decoded as illegal opcode -> one cmd_error pulse.
REQ-043 Strobe 0x9A in IDLE -> cmd_error pulse, no cfg_update, busy stays 0.
